ro_window_counter: RTL and testbench
====================================

// Module: ro_window_counter
// PURPOSE
//  Counts rising edges on N_CH asynchronous ring-oscillator outputs over a
//  programmable gate window timed in the clk domain. Sits between the RO array
//  and the PUF response comparator. Per-channel counts feed challenge/response
//  bit generation. Multi-channel, windowed, overflow-aware successor to the
//  single edge-clocked counter.
// PARAMETERS
//  N_CH      2   number of oscillator channels
//  CNT_W     16  width of each per-channel edge counter
//  WIN_W     16  width of the window-length field
//  SAT_MODE  1   1 = saturate at all-ones on overflow; 0 = wrap to 0
// PORTS
//  clk      in   1           system clock, rising edge
//  rst      in   1           asynchronous, active-high reset
//  start    in   1           request a measurement; sampled in IDLE only
//  win_len  in   WIN_W       window length in clk cycles; captured on accepted start
//  ro_in    in   N_CH        asynchronous oscillator outputs
//  busy     out  1           high in ARM and COUNT
//  done     out  1           one-cycle pulse when a measurement completes
//  valid    out  1           counts/ovf hold a completed result
//  counts   out  N_CH*CNT_W  channel i at [i*CNT_W +: CNT_W]
//  ovf      out  N_CH        sticky per-channel overflow flag
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE.
//    busy, done, valid, counts, ovf, timer and all sync flops = 0.
//  - Input path, per channel: 2-flop synchronizer, then a 3rd flop.
//    edge_i = s2 & ~s3. Only rising edges count; levels never count.
//    Inputs faster than clk/2 undercount. This is not detected or flagged.
//  - FSM states: IDLE, ARM, COUNT, DONE.
//  - IDLE, start=1, win_len!=0: latch win_len, go to ARM.
//  - IDLE, start=1, win_len==0: go directly to DONE. Clear counts and ovf.
//  - ARM (1 cycle): clear counts, ovf and valid. Load timer=win_len.
//    Edges in ARM are discarded. Go to COUNT.
//  - COUNT: exactly win_len cycles.
//    Edges detected in these cycles increment their counters.
//    Timer decrements each cycle. timer==1 -> DONE on the next edge.
//  - DONE (1 cycle): done=1. valid set to 1. Go to IDLE.
//  - Latency: start accepted at cycle t -> done high at cycle t+win_len+2.
//    For win_len==0, done is high at t+1.
//  - start outside IDLE is ignored. This includes start in the same cycle as done.
//  - valid stays high until the next accepted start clears it in ARM.
//  - counts show live partial values during COUNT (valid=0).
//    Outside COUNT they are stable.
//  - Overflow (counter all-ones and an edge arrives):
//    SAT_MODE=1: counter holds all-ones. SAT_MODE=0: counter wraps to 0.
//    Either mode: ovf[i]=1, sticky until ARM or reset.
//  - Channels are independent. Simultaneous edges on all channels all count in the same cycle.
//  - rst mid-measurement: immediate return to IDLE. Partial results are lost (counts=0).
//  - Width rules: counters are unsigned CNT_W bits. Timer is unsigned WIN_W bits.
//    No arithmetic crosses channels.
// TESTING
//  1. N_CH=2; ro_in[0] period 4 clk, ro_in[1] period 8; win_len=64
//     -> done at start+66, counts 16/8 (+-1 phase), ovf=00, valid=1.
//  2. CNT_W=4, SAT_MODE=1, period 4, win_len=100 -> count 15, ovf=1.
//     Same stimulus with SAT_MODE=0 -> count 9 (25 mod 16), ovf=1.
//  3. win_len=0 -> done at start+1, counts 0, ovf 0, valid=1, busy never high.
//  4. start re-pulsed during COUNT and again on the done cycle
//     -> both ignored; done timing and counts are unchanged.
//  5. rst asserted mid-COUNT, between clk edges -> all outputs 0 immediately.
//     Next start with win_len=8 completes normally at start+10.
//  6. ro_in held high across start, or static low -> count 0, ovf 0.

Source files
------------

// File: rtl/ro_window_counter.sv
// Windowed rising-edge counter for an array of asynchronous ring oscillators.
// Each channel is synchronised, edge-detected and counted over a clk-timed gate window.
module ro_window_counter #(
  parameter int N_CH     = 2,
  parameter int CNT_W    = 16,
  parameter int WIN_W    = 16,
  parameter int SAT_MODE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WIN_W-1:0]       win_len,
  input  logic [N_CH-1:0]        ro_in,
  output logic                   busy,
  output logic                   done,
  output logic                   valid,
  output logic [N_CH*CNT_W-1:0]  counts,
  output logic [N_CH-1:0]        ovf
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_COUNT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [WIN_W-1:0]        win_q, win_d;
  logic [WIN_W-1:0]        timer_q, timer_d;
  logic [N_CH*CNT_W-1:0]   counts_q, counts_d;
  logic [N_CH-1:0]         ovf_q, ovf_d;
  logic                    valid_q, valid_d;
  logic [N_CH-1:0]         s1_q, s2_q, s3_q;
  logic [N_CH-1:0]         s1_d, s2_d, s3_d;
  logic [N_CH-1:0]         edge_hit;
  logic [CNT_W-1:0]        cur;

  assign edge_hit = s2_q & ~s3_q;

  always_comb begin
    s1_d     = ro_in;
    s2_d     = s1_q;
    s3_d     = s2_q;
    state_d  = state_q;
    win_d    = win_q;
    timer_d  = timer_q;
    counts_d = counts_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;
    cur      = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (win_len != '0) begin
            win_d   = win_len;
            state_d = S_ARM;
          end else begin
            counts_d = '0;
            ovf_d    = '0;
            valid_d  = 1'b1;
            state_d  = S_DONE;
          end
        end
      end
      S_ARM: begin
        counts_d = '0;
        ovf_d    = '0;
        valid_d  = 1'b0;
        timer_d  = win_q;
        state_d  = S_COUNT;
      end
      S_COUNT: begin
        timer_d = timer_q - WIN_W'(1);
        if (timer_q == WIN_W'(1)) begin
          valid_d = 1'b1;
          state_d = S_DONE;
        end
        for (int i = 0; i < N_CH; i++) begin
          cur = counts_q[i*CNT_W +: CNT_W];
          if (edge_hit[i]) begin
            // Overflow: the all-ones counter either pins or rolls over, flag is sticky
            if (&cur) begin
              ovf_d[i] = 1'b1;
              counts_d[i*CNT_W +: CNT_W] = (SAT_MODE != 0) ? cur : '0;
            end else begin
              counts_d[i*CNT_W +: CNT_W] = cur + CNT_W'(1);
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      win_q    <= '0;
      timer_q  <= '0;
      counts_q <= '0;
      ovf_q    <= '0;
      valid_q  <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
      s3_q     <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      timer_q  <= timer_d;
      counts_q <= counts_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
    end
  end

  assign busy   = (state_q == S_ARM) || (state_q == S_COUNT);
  assign done   = (state_q == S_DONE);
  assign valid  = valid_q;
  assign counts = counts_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_ro_window_counter.sv
// Directed bench for ro_window_counter: expected results are queued at start and
// checked when done fires; 4-bit saturating and wrapping instances cover overflow.
module tb_ro_window_counter;

  logic        clk, rst, start;
  logic [15:0] win_len;
  logic [1:0]  ro_in;
  logic        osc0, osc1;
  int          ro_mode;

  logic        busy, done, valid;
  logic [31:0] counts;
  logic [1:0]  ovf;
  logic        sat_busy, sat_done, sat_valid;
  logic [7:0]  sat_counts;
  logic [1:0]  sat_ovf;
  logic        wrp_busy, wrp_done, wrp_valid;
  logic [7:0]  wrp_counts;
  logic [1:0]  wrp_ovf;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         lat;
    int         lo0, hi0, lo1, hi1;
    logic [1:0] ovf;
  } exp_t;
  exp_t sb[$];

  ro_window_counter u_main (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .ro_in(ro_in),
    .busy(busy), .done(done), .valid(valid), .counts(counts), .ovf(ovf));

  ro_window_counter #(.CNT_W(4), .SAT_MODE(1)) u_sat (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .ro_in(ro_in),
    .busy(sat_busy), .done(sat_done), .valid(sat_valid), .counts(sat_counts), .ovf(sat_ovf));

  ro_window_counter #(.CNT_W(4), .SAT_MODE(0)) u_wrp (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len), .ro_in(ro_in),
    .busy(wrp_busy), .done(wrp_done), .valid(wrp_valid), .counts(wrp_counts), .ovf(wrp_ovf));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Oscillators: period 4 and 8 clk, toggling well away from clk edges
  initial begin
    osc0 = 1'b0;
    #2;
    forever #20 osc0 = ~osc0;
  end
  initial begin
    osc1 = 1'b0;
    #2;
    forever #40 osc1 = ~osc1;
  end
  assign ro_in = (ro_mode == 0) ? {osc1, osc0} : ((ro_mode == 1) ? 2'b00 : 2'b11);

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input longint obs, input longint lo, input longint hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int wl, input int lo0, input int hi0, input int lo1, input int hi1,
                     input logic [1:0] eovf, input bit rep);
    exp_t e;
    int   n;
    bit   seen_busy, got;
    e.lat = (wl == 0) ? 1 : wl + 2;
    e.lo0 = lo0; e.hi0 = hi0; e.lo1 = lo1; e.hi1 = hi1; e.ovf = eovf;
    sb.push_back(e);
    win_len   = 16'(wl);
    start     = 1'b1;
    n         = 0;
    seen_busy = 1'b0;
    got       = 1'b0;
    while (!got && n < 1000) begin
      tick();
      n++;
      start = 1'b0;
      if (busy) seen_busy = 1'b1;
      if (rep && n == 10) begin
        chk("count_busy", busy, 1);
        chk("count_valid_low", valid, 0);
        start = 1'b1;
      end
      if (done) got = 1'b1;
    end
    chk("done_seen", got, 1);
    e = sb.pop_front();
    chk("latency", n, e.lat);
    chk_rng("count_ch0", counts[15:0], e.lo0, e.hi0);
    chk_rng("count_ch1", counts[31:16], e.lo1, e.hi1);
    chk("ovf", ovf, e.ovf);
    chk("valid_at_done", valid, 1);
    if (wl == 0) chk("busy_never", seen_busy, 0);
    if (rep) start = 1'b1;
    tick();
    start = 1'b0;
    chk("idle_after_done", busy, 0);
    chk("done_pulse_width", done, 0);
    chk("valid_held", valid, 1);
    chk_rng("hold_ch0", counts[15:0], e.lo0, e.hi0);
    chk_rng("hold_ch1", counts[31:16], e.lo1, e.hi1);
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    win_len = '0;
    ro_mode = 0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", valid, 0);
    chk("rst_counts", counts, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_sat_busy", {sat_busy, wrp_busy}, 0);
    rst = 1'b0;
    repeat (5) tick();

    // Nominal window: period-4 and period-8 channels over 64 cycles
    run(64, 16, 16, 8, 8, 2'b00, 1'b0);

    // 100-cycle window: 25 edges overflow the 4-bit instances
    win_len = 16'd100;
    run(100, 25, 25, 12, 13, 2'b00, 1'b0);
    chk("sat_done_valid", {sat_valid, wrp_valid}, 2'b11);
    chk("sat_ch0", sat_counts[3:0], 15);
    chk_rng("sat_ch1", sat_counts[7:4], 12, 13);
    chk("sat_ovf", sat_ovf, 2'b01);
    chk("wrp_ch0", wrp_counts[3:0], 9);
    chk_rng("wrp_ch1", wrp_counts[7:4], 12, 13);
    chk("wrp_ovf", wrp_ovf, 2'b01);

    // Zero-length window goes straight to DONE
    run(0, 0, 0, 0, 0, 2'b00, 1'b0);
    chk("zero_done_seen", {sat_done, wrp_done}, 2'b00);

    // Start re-pulsed in COUNT and on the done cycle is ignored
    run(64, 16, 16, 8, 8, 2'b00, 1'b1);

    // Reset between clk edges in the middle of COUNT
    win_len = 16'd64;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    chk("pre_rst_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_counts", counts, 0);
    chk("mid_rst_ovf", ovf, 0);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    run(8, 2, 2, 1, 1, 2'b00, 1'b0);

    // Static low, then static high across start
    ro_mode = 1;
    repeat (10) tick();
    run(32, 0, 0, 0, 0, 2'b00, 1'b0);
    ro_mode = 2;
    repeat (10) tick();
    run(32, 0, 0, 0, 0, 2'b00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
